morse_encode_and_transmit_word: RTL and testbench

MORSE_ENCODE_AND_TRANSMIT_WORD -- requirements
Module: morse_encode_and_transmit_word

---
 rtl/morse_encode_and_transmit_word.sv | 197 +++++++++++++++++++
 tb/tb_morse_encode_and_transmit_word.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_encode_and_transmit_word.sv
// Morse keyer: shifts a packed word out one character at a time as timed marks and gaps.
// Optional abort input is enabled by defining MORSE_TX_ABORT_EN.
`ifndef CHAR_W
`define CHAR_W 6
`endif
`ifndef MAX_CHARS
`define MAX_CHARS 4
`endif
`ifndef PULSE_CNT_W
`define PULSE_CNT_W 8
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 3
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 5
`endif

module morse_encode_and_transmit_word #(
    parameter int DEBUG = 0
) (
    input  logic                            clk,
    input  logic                            aclr,
    input  logic                            ce,
    input  logic [`PULSE_CNT_W-1:0]         dit_time,
    input  logic [`PULSE_CNT_W-1:0]         dah_time,
    input  logic [`PULSE_CNT_W-1:0]         word_time,
    input  logic                            start,
    input  logic [`CHAR_W*`MAX_CHARS-1:0]   word,
`ifdef MORSE_TX_ABORT_EN
    input  logic                            abort,
`endif
    output logic                            signal,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [2:0]                      dbg_state
);
    localparam int CW = `CHAR_W;
    localparam int MC = `MAX_CHARS;
    localparam int PW = `PULSE_CNT_W;
    localparam int LW = `MORSE_LEN_W;
    localparam int ML = `MAX_MORSE_LEN;
    localparam int IW = $clog2(MC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MARK, S_ELEM_GAP, S_CHAR_GAP, S_WORD_GAP, S_FIN
    } state_t;

    state_t              state;
    logic [CW*MC-1:0]    word_sr;
    logic [IW-1:0]       char_idx;
    logic [PW-1:0]       cnt;
    logic [ML-1:0]       pat;
    logic [LW-1:0]       len_rem;
    logic [LW+ML-1:0]    lk;
    logic [CW*MC-1:0]    sr_next;
    logic                abort_req;
    logic                last_char;

    function automatic logic [LW+ML-1:0] ent(input int len, input int code_bits);
        ent = {LW'(len), ML'(code_bits)};
    endfunction

    // Table: codes 1..26 = A..Z, 27..36 = 0..9; elements bit 0 first, 1 = dah; length 0 = unmapped.
    function automatic logic [LW+ML-1:0] lookup(input logic [CW-1:0] code);
        case (int'(code))
            1:  lookup = ent(2, 'b10);    2:  lookup = ent(4, 'b0001);
            3:  lookup = ent(4, 'b0101);  4:  lookup = ent(3, 'b001);
            5:  lookup = ent(1, 'b0);     6:  lookup = ent(4, 'b0100);
            7:  lookup = ent(3, 'b011);   8:  lookup = ent(4, 'b0000);
            9:  lookup = ent(2, 'b00);    10: lookup = ent(4, 'b1110);
            11: lookup = ent(3, 'b101);   12: lookup = ent(4, 'b0010);
            13: lookup = ent(2, 'b11);    14: lookup = ent(2, 'b01);
            15: lookup = ent(3, 'b111);   16: lookup = ent(4, 'b0110);
            17: lookup = ent(4, 'b1011);  18: lookup = ent(3, 'b010);
            19: lookup = ent(3, 'b000);   20: lookup = ent(1, 'b1);
            21: lookup = ent(3, 'b100);   22: lookup = ent(4, 'b1000);
            23: lookup = ent(3, 'b110);   24: lookup = ent(4, 'b1001);
            25: lookup = ent(4, 'b1101);  26: lookup = ent(4, 'b0011);
            27: lookup = ent(5, 'b11111); 28: lookup = ent(5, 'b11110);
            29: lookup = ent(5, 'b11100); 30: lookup = ent(5, 'b11000);
            31: lookup = ent(5, 'b10000); 32: lookup = ent(5, 'b00000);
            33: lookup = ent(5, 'b00001); 34: lookup = ent(5, 'b00011);
            35: lookup = ent(5, 'b00111); 36: lookup = ent(5, 'b01111);
            default: lookup = '0;
        endcase
    endfunction

    function automatic logic [PW-1:0] eff(input logic [PW-1:0] t);
        eff = (t == '0) ? PW'(1) : t;
    endfunction

`ifdef MORSE_TX_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign lk        = lookup(word_sr[CW-1:0]);
    assign sr_next   = word_sr >> CW;
    assign last_char = ((char_idx + IW'(1)) == IW'(MC)) || (sr_next[CW-1:0] == '0);
    assign dbg_state = (DEBUG != 0) ? state : 3'd0;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state    <= S_IDLE;
            word_sr  <= '0;
            char_idx <= '0;
            cnt      <= '0;
            pat      <= '0;
            len_rem  <= '0;
            signal   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else if (ce) begin
            if (abort_req && busy && state != S_FIN) begin
                signal <= 1'b0;
                error  <= 1'b1;
                done   <= 1'b1;
                state  <= S_FIN;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        word_sr  <= word;
                        char_idx <= '0;
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        state    <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (char_idx == IW'(MC) || word_sr[CW-1:0] == '0) begin
                            cnt   <= eff(word_time);
                            state <= S_WORD_GAP;
                        end else if (lk[LW+ML-1:ML] == '0) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            pat     <= lk[ML-1:0];
                            len_rem <= lk[LW+ML-1:ML];
                            cnt     <= lk[0] ? eff(dah_time) : eff(dit_time);
                            signal  <= 1'b1;
                            state   <= S_MARK;
                        end
                    end
                    S_MARK: if (cnt > PW'(1)) begin
                        cnt <= cnt - PW'(1);
                    end else begin
                        signal <= 1'b0;
                        if (len_rem > LW'(1)) begin
                            pat     <= pat >> 1;
                            len_rem <= len_rem - LW'(1);
                            cnt     <= eff(dit_time);
                            state   <= S_ELEM_GAP;
                        end else begin
                            word_sr  <= sr_next;
                            char_idx <= char_idx + IW'(1);
                            if (last_char) begin
                                cnt   <= eff(word_time);
                                state <= S_WORD_GAP;
                            end else if (eff(dah_time) == PW'(1)) begin
                                state <= S_LOAD;
                            end else begin
                                // The LOAD tick is the final tick of the inter-character space.
                                cnt   <= eff(dah_time) - PW'(1);
                                state <= S_CHAR_GAP;
                            end
                        end
                    end
                    S_ELEM_GAP: if (cnt > PW'(1)) begin
                        cnt <= cnt - PW'(1);
                    end else begin
                        cnt    <= pat[0] ? eff(dah_time) : eff(dit_time);
                        signal <= 1'b1;
                        state  <= S_MARK;
                    end
                    S_CHAR_GAP: if (cnt > PW'(1)) cnt <= cnt - PW'(1);
                                else state <= S_LOAD;
                    S_WORD_GAP: if (cnt > PW'(1)) begin
                        cnt <= cnt - PW'(1);
                    end else begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                    S_FIN: begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_morse_encode_and_transmit_word.sv
// Directed bench for the Morse word keyer: signal traces are reduced to run lengths and checked.
`ifndef CHAR_W
`define CHAR_W 6
`endif
`ifndef MAX_CHARS
`define MAX_CHARS 4
`endif
`ifndef PULSE_CNT_W
`define PULSE_CNT_W 8
`endif

module tb_morse_encode_and_transmit_word;
    localparam int CW = `CHAR_W;
    localparam int MC = `MAX_CHARS;
    localparam int PW = `PULSE_CNT_W;
    localparam int CH_A = 1, CH_E = 5, CH_T = 20, CH_BAD = 63;

    logic              clk = 1'b0;
    logic              aclr, ce, start;
    logic [PW-1:0]     dit_time, dah_time, word_time;
    logic [CW*MC-1:0]  word;
    logic              signal, busy, done, error;
    logic [2:0]        dbg_state;
`ifdef MORSE_TX_ABORT_EN
    logic              abort;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    always #5 clk = ~clk;

    morse_encode_and_transmit_word #(.DEBUG(1)) dut (
        .clk(clk), .aclr(aclr), .ce(ce),
        .dit_time(dit_time), .dah_time(dah_time), .word_time(word_time),
        .start(start), .word(word),
`ifdef MORSE_TX_ABORT_EN
        .abort(abort),
`endif
        .signal(signal), .busy(busy), .done(done), .error(error),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hi(input int n);
        hi = 16'h8000 | 16'(n);
    endfunction
    function automatic logic [15:0] lo(input int n);
        lo = 16'(n);
    endfunction

    function automatic logic [CW*MC-1:0] pack(input int c0, input int c1, input int c2, input int c3);
        pack = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endfunction

    // Starts a word, records signal on every ce tick until done, compares runs with exp_q.
    task automatic run_word(input string tag, input logic [CW*MC-1:0] w, input logic exp_err,
                            input int hold_at, input int hold_len, output int raw_high);
        int cyc;
        logic [15:0] cur;
        word = w;
        got_q.delete();
        raw_high = 0;
        ce = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_on_start"}, busy, 1);
        check({tag, " error_cleared"}, error, 0);
        cyc = 0;
        cur = '0;
        while (!done && cyc < 400) begin
            ce = !(hold_at >= 0 && cyc >= hold_at && cyc < hold_at + hold_len);
            if (signal) raw_high++;
            if (ce) begin
                if (cur[14:0] != 0 && cur[15] == signal) cur = cur + 16'd1;
                else begin
                    if (cur[14:0] != 0) got_q.push_back(cur);
                    cur = {signal, 15'd1};
                end
            end
            @(negedge clk);
            cyc++;
        end
        ce = 1'b1;
        if (cur[14:0] != 0) got_q.push_back(cur);
        check({tag, " done_seen"}, done, 1);
        check({tag, " run_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s run%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, " error_at_done"}, error, exp_err);
        check({tag, " busy_at_done"}, busy, 1);
        @(negedge clk);
        check({tag, " done_one_tick"}, done, 0);
        check({tag, " busy_after"}, busy, 0);
        exp_q.delete();
    endtask

    initial begin
        int rh;
        int done_cnt;
        aclr = 1'b1; ce = 1'b0; start = 1'b0; word = '0;
        dit_time = 8'd2; dah_time = 8'd6; word_time = 8'd14;
`ifdef MORSE_TX_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset signal", signal, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset error", error, 0);
        aclr = 1'b0;
        ce = 1'b1;
        @(negedge clk);
        check("idle no start", busy, 0);

        exp_q = '{lo(1), hi(2), lo(14)};
        run_word("E", pack(CH_E, 0, 0, 0), 1'b0, -1, 0, rh);

        exp_q = '{lo(1), hi(2), lo(6), hi(6), lo(14)};
        run_word("ET", pack(CH_E, CH_T, 0, 0), 1'b0, -1, 0, rh);

        exp_q = '{lo(1), hi(2), lo(2), hi(6), lo(14)};
        run_word("A", pack(CH_A, 0, 0, 0), 1'b0, -1, 0, rh);

        exp_q = '{lo(1), hi(2), lo(6), hi(2), lo(6), hi(2), lo(6), hi(2), lo(14)};
        run_word("EEEE", pack(CH_E, CH_E, CH_E, CH_E), 1'b0, -1, 0, rh);

        exp_q = '{lo(15)};
        run_word("empty", pack(0, 0, 0, 0), 1'b0, -1, 0, rh);

        exp_q = '{lo(1)};
        run_word("bad", pack(CH_BAD, CH_E, 0, 0), 1'b1, -1, 0, rh);
        check("bad high_cycles", rh, 0);
        repeat (2) @(negedge clk);
        check("error sticky", error, 1);

        exp_q = '{lo(1), hi(2), lo(14)};
        run_word("E_after_bad", pack(CH_E, 0, 0, 0), 1'b0, -1, 0, rh);

        // ce held low for 10 cycles inside the dah: length in ticks unchanged, 16 raw high cycles.
        exp_q = '{lo(1), hi(6), lo(14)};
        run_word("T_ce_hold", pack(CH_T, 0, 0, 0), 1'b0, 3, 10, rh);
        check("T_ce_hold raw_high", rh, 16);

        dit_time = '0; dah_time = '0; word_time = '0;
        exp_q = '{lo(1), hi(1), lo(1), hi(1), lo(1)};
        run_word("ET_zero_times", pack(CH_E, CH_T, 0, 0), 1'b0, -1, 0, rh);
        dit_time = 8'd2; dah_time = 8'd6; word_time = 8'd14;

        word = pack(CH_T, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("aclr pre signal", signal, 1);
        aclr = 1'b1;
        #1;
        check("aclr signal", signal, 0);
        check("aclr busy", busy, 0);
        @(negedge clk);
        aclr = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("aclr no_done", done_cnt, 0);
        check("aclr idle", busy, 0);

        exp_q = '{lo(1), hi(2), lo(14)};
        run_word("E_after_aclr", pack(CH_E, 0, 0, 0), 1'b0, -1, 0, rh);

`ifdef MORSE_TX_ABORT_EN
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort idle_ignored", busy, 0);
        check("abort idle_no_err", error, 0);
        word = pack(CH_A, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort pre_gap", signal, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort done", done, 1);
        check("abort error", error, 1);
        check("abort signal", signal, 0);
        rh = 0;
        for (int i = 0; i < 10; i++) begin
            if (signal) rh++;
            @(negedge clk);
        end
        check("abort no_mark", rh, 0);
        check("abort busy_off", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
